move_sequencer: RTL and testbench

- Controller that turns a requested move (from-square, to-square) into write commands for the 256-bit board register.
- Sits between the input/move-entry logic and the board builder. Reads the current board, checks basic legality, then issues two single-square writes on the changePiece bus: destination first, then source cleared.
- Owns the side-to-move flag.

---
 rtl/move_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_move_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/move_sequencer.sv
// move_sequencer
// Turns a requested move (from-square, to-square) into two single-square
// writes on the changePiece bus of the 256-bit board register: the moving
// piece is written to the destination first, then the source is cleared.
// The block reads the current board, applies basic legality checks and owns
// the side-to-move flag.
//
// Optional feature macro: CAPTURE_CNT_EN adds per-side capture counters
// (cap_white / cap_black). Without it those ports and their logic are absent.
//
// Parameters:
//   WR_LAT        idle cycles after each board write (0..7)
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   currentState  game state, 3'b000 = setup (aborts and holds the block idle)
//   board         board image, square sq occupies board[sq*4 +: 4] = {colour,type}
//   move_valid    move request valid
//   move_from     source square index
//   move_to       destination square index
//   move_ready    request accepted when move_valid & move_ready at clk edge
//   changePiece   {write_en, piece[3:0], square[5:0]}
//   move_done     one-cycle pulse, move applied
//   move_err      one-cycle pulse, move rejected
//   err_code      01 empty source, 10 wrong colour, 11 bad destination
//   turn          side to move, 0 = white, 1 = black
//   cap_white     pieces captured by white (CAPTURE_CNT_EN only)
//   cap_black     pieces captured by black (CAPTURE_CNT_EN only)

module move_sequencer #(
  parameter int unsigned WR_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   currentState,
  input  logic [255:0] board,
  input  logic         move_valid,
  input  logic [5:0]   move_from,
  input  logic [5:0]   move_to,
  output logic         move_ready,
  output logic [10:0]  changePiece,
  output logic         move_done,
  output logic         move_err,
  output logic [1:0]   err_code,
  output logic         turn
`ifdef CAPTURE_CNT_EN
  ,
  output logic [3:0]   cap_white,
  output logic [3:0]   cap_black
`endif
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] FETCH    = 4'd1;
  localparam logic [3:0] CHECK    = 4'd2;
  localparam logic [3:0] WR_DST   = 4'd3;
  localparam logic [3:0] WAIT_D   = 4'd4;
  localparam logic [3:0] WR_SRC   = 4'd5;
  localparam logic [3:0] WAIT_S   = 4'd6;
  localparam logic [3:0] DONE_OK  = 4'd7;
  localparam logic [3:0] DONE_ERR = 4'd8;

  localparam logic [2:0] SETUP    = 3'b000;
  localparam logic [2:0] EMPTY    = 3'b000;

  // Wait counter counts down to zero, so it is loaded with WR_LAT-1.
  localparam logic [2:0] WAIT_INIT = (WR_LAT == 0) ? 3'd0 : 3'(WR_LAT - 1);

  logic [3:0]  state_q, state_d;
  logic [5:0]  from_q, from_d;
  logic [5:0]  to_q, to_d;
  logic [3:0]  src_q, src_d;
  logic [3:0]  dst_q, dst_d;
  logic [1:0]  err_q, err_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        turn_q, turn_d;
  logic [10:0] cp_q, cp_d;
  logic        done_q, done_d;
  logic        merr_q, merr_d;

  assign move_ready = (state_q == IDLE) && (currentState != SETUP);

  // Next-state logic. The setup override is applied last so it wins over
  // every transition, including the turn toggle out of DONE_OK.
  always_comb begin
    state_d = state_q;
    from_d  = from_q;
    to_d    = to_q;
    src_d   = src_q;
    dst_d   = dst_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    turn_d  = turn_q;

    case (state_q)
      IDLE: begin
        if (move_valid && move_ready) begin
          from_d  = move_from;
          to_d    = move_to;
          err_d   = 2'b00;
          state_d = FETCH;
        end
      end
      FETCH: begin
        src_d   = board[{from_q, 2'b00} +: 4];
        dst_d   = board[{to_q, 2'b00} +: 4];
        state_d = CHECK;
      end
      CHECK: begin
        if (src_q[2:0] == EMPTY) begin
          err_d   = 2'b01;
          state_d = DONE_ERR;
        end else if (src_q[3] != turn_q) begin
          err_d   = 2'b10;
          state_d = DONE_ERR;
        end else if ((from_q == to_q) ||
                     ((dst_q[2:0] != EMPTY) && (dst_q[3] == turn_q))) begin
          err_d   = 2'b11;
          state_d = DONE_ERR;
        end else begin
          err_d   = 2'b00;
          state_d = WR_DST;
        end
      end
      WR_DST: begin
        if (WR_LAT == 0) begin
          state_d = WR_SRC;
        end else begin
          cnt_d   = WAIT_INIT;
          state_d = WAIT_D;
        end
      end
      WAIT_D: begin
        if (cnt_q == 3'd0) state_d = WR_SRC;
        else               cnt_d   = cnt_q - 3'd1;
      end
      WR_SRC: begin
        if (WR_LAT == 0) begin
          state_d = DONE_OK;
        end else begin
          cnt_d   = WAIT_INIT;
          state_d = WAIT_S;
        end
      end
      WAIT_S: begin
        if (cnt_q == 3'd0) state_d = DONE_OK;
        else               cnt_d   = cnt_q - 3'd1;
      end
      DONE_OK: begin
        turn_d  = ~turn_q;
        state_d = IDLE;
      end
      DONE_ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (currentState == SETUP) begin
      state_d = IDLE;
      turn_d  = 1'b0;
    end
  end

  // Outputs are registered and decoded from the upcoming state so the bus
  // and pulses line up exactly with the WR_*/DONE_* states.
  always_comb begin
    cp_d   = 11'd0;
    done_d = (state_d == DONE_OK);
    merr_d = (state_d == DONE_ERR);
    if (state_d == WR_DST) cp_d = {1'b1, src_d, to_d};
    else if (state_d == WR_SRC) cp_d = {1'b1, 4'b0000, from_d};
  end

  // Main state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      from_q  <= 6'd0;
      to_q    <= 6'd0;
      src_q   <= 4'd0;
      dst_q   <= 4'd0;
      err_q   <= 2'b00;
      cnt_q   <= 3'd0;
      turn_q  <= 1'b0;
      cp_q    <= 11'd0;
      done_q  <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      from_q  <= from_d;
      to_q    <= to_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      turn_q  <= turn_d;
      cp_q    <= cp_d;
      done_q  <= done_d;
      merr_q  <= merr_d;
    end
  end

  assign changePiece = cp_q;
  assign move_done   = done_q;
  assign move_err    = merr_q;
  assign err_code    = err_q;
  assign turn        = turn_q;

`ifdef CAPTURE_CNT_EN
  logic [3:0] capW_q, capB_q;

  // A completed move onto an occupied square is a capture credited to the
  // side that moved (turn has not toggled yet while in DONE_OK).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      capW_q <= 4'd0;
      capB_q <= 4'd0;
    end else if (currentState == SETUP) begin
      capW_q <= 4'd0;
      capB_q <= 4'd0;
    end else if ((state_q == DONE_OK) && (dst_q[2:0] != EMPTY)) begin
      if (!turn_q && (capW_q != 4'd15)) capW_q <= capW_q + 4'd1;
      if (turn_q && (capB_q != 4'd15))  capB_q <= capB_q + 4'd1;
    end
  end

  assign cap_white = capW_q;
  assign cap_black = capB_q;
`endif

endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer
// Directed bench for move_sequencer. Two instances are used: dut (WR_LAT=1)
// and dut0 (WR_LAT=0). They share clock, reset, currentState, board and the
// from/to squares; each has its own move_valid so moves are issued to one
// instance at a time.

module tb_move_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   currentState;
  logic [255:0] board;
  logic         move_valid, move_valid0;
  logic [5:0]   move_from, move_to;

  logic         move_ready, move_done, move_err, turn;
  logic [10:0]  changePiece;
  logic [1:0]   err_code;
  logic         move_ready0, move_done0, move_err0, turn0;
  logic [10:0]  changePiece0;
  logic [1:0]   err_code0;
`ifdef CAPTURE_CNT_EN
  logic [3:0]   capWhite, capBlack, capWhite0, capBlack0;
`endif

  int checks = 0;
  int errors = 0;

  // Results collected by run_move for the scenario tasks to judge.
  int          wrCount, wr0Cyc, wr1Cyc, doneCyc, doneCount, errCyc, errCount, leakCount;
  logic [10:0] wr0Val, wr1Val;

  always #5 clk = ~clk;

  move_sequencer #(.WR_LAT(1)) dut (
    .clk(clk), .rst(rst), .currentState(currentState), .board(board),
    .move_valid(move_valid), .move_from(move_from), .move_to(move_to),
    .move_ready(move_ready), .changePiece(changePiece), .move_done(move_done),
    .move_err(move_err), .err_code(err_code), .turn(turn)
`ifdef CAPTURE_CNT_EN
    , .cap_white(capWhite), .cap_black(capBlack)
`endif
  );

  move_sequencer #(.WR_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .currentState(currentState), .board(board),
    .move_valid(move_valid0), .move_from(move_from), .move_to(move_to),
    .move_ready(move_ready0), .changePiece(changePiece0), .move_done(move_done0),
    .move_err(move_err0), .err_code(err_code0), .turn(turn0)
`ifdef CAPTURE_CNT_EN
    , .cap_white(capWhite0), .cap_black(capBlack0)
`endif
  );

  // Opening position: black rooks on 0/56, black pawns row 1, white pawns
  // row 6, white back rank row 7 (king on square 39).
  function automatic logic [255:0] startBoard();
    logic [255:0] b;
    logic [2:0]   backRow [8] = '{3'b101, 3'b100, 3'b011, 3'b010,
                                  3'b001, 3'b011, 3'b100, 3'b101};
    b = '0;
    b[0*4 +: 4]  = 4'b1101;
    b[56*4 +: 4] = 4'b1101;
    for (int c = 0; c < 8; c++) begin
      b[(c*8+1)*4 +: 4] = 4'b1110;
      b[(c*8+6)*4 +: 4] = 4'b0110;
      b[(c*8+7)*4 +: 4] = {1'b0, backRow[c]};
    end
    return b;
  endfunction

  // Issues one request and records ncyc cycles of bus/pulse activity, with
  // cycle 1 being the first cycle after the accept edge. If abortCyc matches
  // a cycle, currentState is driven to setup right after that cycle's sample.
  task automatic run_move(input logic [5:0] f, input logic [5:0] t,
                          input int ncyc, input bit use0, input int abortCyc);
    logic [10:0] cp;
    logic        dn, er;
    wrCount = 0; wr0Cyc = 0; wr1Cyc = 0; doneCyc = 0; doneCount = 0;
    errCyc = 0; errCount = 0; leakCount = 0; wr0Val = '0; wr1Val = '0;
    @(negedge clk);
    move_from = f;
    move_to   = t;
    if (use0) move_valid0 = 1'b1;
    else      move_valid  = 1'b1;
    @(negedge clk);
    move_valid  = 1'b0;
    move_valid0 = 1'b0;
    move_from   = 6'd0;
    move_to     = 6'd0;
    for (int c = 1; c <= ncyc; c++) begin
      if (c > 1) @(negedge clk);
      cp = use0 ? changePiece0 : changePiece;
      dn = use0 ? move_done0 : move_done;
      er = use0 ? move_err0 : move_err;
      if (cp[10]) begin
        if (wrCount == 0) begin wr0Cyc = c; wr0Val = cp; end
        if (wrCount == 1) begin wr1Cyc = c; wr1Val = cp; end
        wrCount++;
      end else if (cp[9:0] != 10'd0) begin
        leakCount++;
      end
      if (dn) begin if (doneCount == 0) doneCyc = c; doneCount++; end
      if (er) begin if (errCount == 0) errCyc = c; errCount++; end
      if (c == abortCyc) currentState = 3'b000;
    end
  endtask

  // Drives currentState to setup for one edge, which clears turn.
  task automatic pulse_setup();
    @(negedge clk);
    currentState = 3'b000;
    @(negedge clk);
    currentState = 3'b001;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (changePiece !== 11'd0) begin errors++; $display("[TB] FAIL reset_cp got %h want 000", changePiece); end
    checks++; if (move_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", move_done); end
    checks++; if (move_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", move_err); end
    checks++; if (err_code !== 2'b00) begin errors++; $display("[TB] FAIL reset_code got %b want 00", err_code); end
    checks++; if (turn !== 1'b0) begin errors++; $display("[TB] FAIL reset_turn got %b want 0", turn); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (move_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_idle got %b want 1", move_ready); end
    currentState = 3'b000;
    #1;
    checks++; if (move_ready !== 1'b0) begin errors++; $display("[TB] FAIL ready_setup got %b want 0", move_ready); end
    currentState = 3'b001;
    #1;
  endtask

  task automatic test_errors();
    logic [5:0] fromTab [4] = '{6'd3, 6'd1, 6'd38, 6'd38};
    logic [5:0] toTab   [4] = '{6'd4, 6'd2, 6'd39, 6'd38};
    logic [1:0] codeTab [4] = '{2'b01, 2'b10, 2'b11, 2'b11};
    for (int i = 0; i < 4; i++) begin
      run_move(fromTab[i], toTab[i], 5, 1'b0, 0);
      checks++; if (errCyc != 3 || errCount != 1) begin errors++; $display("[TB] FAIL err%0d_pulse got cycle %0d count %0d want cycle 3 count 1", i, errCyc, errCount); end
      checks++; if (err_code !== codeTab[i]) begin errors++; $display("[TB] FAIL err%0d_code got %b want %b", i, err_code, codeTab[i]); end
      checks++; if (wrCount != 0) begin errors++; $display("[TB] FAIL err%0d_nowrite got %0d writes want 0", i, wrCount); end
      checks++; if (doneCount != 0) begin errors++; $display("[TB] FAIL err%0d_nodone got %0d want 0", i, doneCount); end
    end
    checks++; if (turn !== 1'b0) begin errors++; $display("[TB] FAIL err_turn got %b want 0", turn); end
  endtask

  task automatic test_legal_move();
    run_move(6'd38, 6'd36, 9, 1'b0, 0);
    checks++; if (wr0Cyc != 3 || wr0Val !== 11'b1_0110_100100) begin errors++; $display("[TB] FAIL legal_wr_dst got %b at %0d want 10110100100 at 3", wr0Val, wr0Cyc); end
    checks++; if (wr1Cyc != 5 || wr1Val !== 11'b1_0000_100110) begin errors++; $display("[TB] FAIL legal_wr_src got %b at %0d want 10000100110 at 5", wr1Val, wr1Cyc); end
    checks++; if (wrCount != 2) begin errors++; $display("[TB] FAIL legal_wr_count got %0d want 2", wrCount); end
    checks++; if (doneCyc != 7 || doneCount != 1) begin errors++; $display("[TB] FAIL legal_done got cycle %0d count %0d want 7/1", doneCyc, doneCount); end
    checks++; if (errCount != 0) begin errors++; $display("[TB] FAIL legal_noerr got %0d want 0", errCount); end
    checks++; if (leakCount != 0) begin errors++; $display("[TB] FAIL legal_bus_idle got %0d leaks want 0", leakCount); end
    checks++; if (turn !== 1'b1) begin errors++; $display("[TB] FAIL legal_turn got %b want 1", turn); end
    checks++; if (err_code !== 2'b00) begin errors++; $display("[TB] FAIL legal_code got %b want 00", err_code); end
  endtask

  task automatic test_capture();
    pulse_setup();
    #1;
    checks++; if (turn !== 1'b0) begin errors++; $display("[TB] FAIL setup_turn got %b want 0", turn); end
    board = startBoard();
    board[36*4 +: 4] = 4'b1110;
    run_move(6'd38, 6'd36, 9, 1'b0, 0);
    checks++; if (wr0Cyc != 3 || wr0Val !== 11'b1_0110_100100) begin errors++; $display("[TB] FAIL cap_wr_dst got %b at %0d want 10110100100 at 3", wr0Val, wr0Cyc); end
    checks++; if (wr1Cyc != 5 || wr1Val !== 11'b1_0000_100110) begin errors++; $display("[TB] FAIL cap_wr_src got %b at %0d want 10000100110 at 5", wr1Val, wr1Cyc); end
    checks++; if (doneCyc != 7) begin errors++; $display("[TB] FAIL cap_done got cycle %0d want 7", doneCyc); end
    checks++; if (turn !== 1'b1) begin errors++; $display("[TB] FAIL cap_turn got %b want 1", turn); end
`ifdef CAPTURE_CNT_EN
    checks++; if (capWhite !== 4'd1) begin errors++; $display("[TB] FAIL cap_white got %0d want 1", capWhite); end
    checks++; if (capBlack !== 4'd0) begin errors++; $display("[TB] FAIL cap_black got %0d want 0", capBlack); end
`endif
  endtask

  task automatic test_abort();
    // Black to move: black pawn 1 -> 2, abort during WAIT_D (cycle 4).
    run_move(6'd1, 6'd2, 8, 1'b0, 4);
    checks++; if (wr0Cyc != 3 || wr0Val !== 11'b1_1110_000010) begin errors++; $display("[TB] FAIL abort_wr_dst got %b at %0d want 11110000010 at 3", wr0Val, wr0Cyc); end
    checks++; if (wrCount != 1) begin errors++; $display("[TB] FAIL abort_no_src got %0d writes want 1", wrCount); end
    checks++; if (doneCount != 0 || errCount != 0) begin errors++; $display("[TB] FAIL abort_pulses got done %0d err %0d want 0/0", doneCount, errCount); end
    checks++; if (turn !== 1'b0) begin errors++; $display("[TB] FAIL abort_turn got %b want 0", turn); end
    checks++; if (move_ready !== 1'b0) begin errors++; $display("[TB] FAIL abort_ready_setup got %b want 0", move_ready); end
    currentState = 3'b001;
    #1;
    checks++; if (move_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_ready_run got %b want 1", move_ready); end
  endtask

  task automatic test_wr_lat0();
    board = startBoard();
    run_move(6'd38, 6'd36, 7, 1'b1, 0);
    checks++; if (wr0Cyc != 3 || wr0Val !== 11'b1_0110_100100) begin errors++; $display("[TB] FAIL lat0_wr_dst got %b at %0d want 10110100100 at 3", wr0Val, wr0Cyc); end
    checks++; if (wr1Cyc != 4 || wr1Val !== 11'b1_0000_100110) begin errors++; $display("[TB] FAIL lat0_wr_src got %b at %0d want 10000100110 at 4", wr1Val, wr1Cyc); end
    checks++; if (doneCyc != 5 || doneCount != 1) begin errors++; $display("[TB] FAIL lat0_done got cycle %0d count %0d want 5/1", doneCyc, doneCount); end
    checks++; if (turn0 !== 1'b1) begin errors++; $display("[TB] FAIL lat0_turn got %b want 1", turn0); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    move_from  = 6'd38;
    move_to    = 6'd36;
    move_valid = 1'b1;
    @(negedge clk);
    move_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (changePiece !== 11'b1_0110_100100) begin errors++; $display("[TB] FAIL rst_pre_wr got %b want 10110100100", changePiece); end
    #2 rst = 1'b1;
    #1;
    checks++; if (changePiece !== 11'd0) begin errors++; $display("[TB] FAIL rst_async_cp got %h want 000", changePiece); end
    checks++; if (move_done !== 1'b0 || move_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_pulses got %b%b want 00", move_done, move_err); end
    checks++; if (turn0 !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_turn got %b want 0", turn0); end
    checks++; if (err_code !== 2'b00) begin errors++; $display("[TB] FAIL rst_async_code got %b want 00", err_code); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (changePiece !== 11'd0 || move_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_recover got cp %h ready %b want 000/1", changePiece, move_ready); end
  endtask

  initial begin
    rst          = 1'b1;
    currentState = 3'b001;
    board        = startBoard();
    move_valid   = 1'b0;
    move_valid0  = 1'b0;
    move_from    = 6'd0;
    move_to      = 6'd0;
    test_reset();
    test_errors();
    test_legal_move();
    test_capture();
    test_abort();
    test_wr_lat0();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
